// File: rtl/wb_mem_arbiter_if.sv
// Wishbone B4 classic bundle for one master/slave link.
// master drives the request side, slave drives the response side.
interface wb_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW/8-1:0] sel;
  logic            ack;
  logic            err;
  logic [DW-1:0]   dat_r;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  ack, err, dat_r
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output ack, err, dat_r
  );
endinterface

// File: rtl/wb_mem_arbiter.sv
// Two-master (fetch M0, mem-stage M1) to one-slave Wishbone arbiter.
// Grants per CYC, routes responses to the owner, aborts stalled slaves.
module wb_mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int RR_EN      = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  wb_mem_arbiter_if.slave  m0,
  wb_mem_arbiter_if.slave  m1,
  wb_mem_arbiter_if.master s,
  output logic [1:0] grant_o,
  output logic       timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    ABORT
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic                  own1;
  logic                  own_cyc;
  logic                  own_stb;
  logic                  own_we;
  logic [ADDR_WIDTH-1:0] own_adr;
  logic [XLEN-1:0]       own_dat;
  logic [XLEN/8-1:0]     own_sel;
  logic                  stall;
  logic                  hit;
  logic                  pick_m1;
  logic                  pick_m0;

  logic                  req_cyc;
  logic                  req_stb;
  logic                  req_mux;
  logic                  rsp_ack;
  logic                  rsp_err;
  logic [XLEN-1:0]       rsp_dat;
  logic                  to_pulse;

  assign own1    = grant_q[1];
  assign own_cyc = own1 ? m1.cyc   : m0.cyc;
  assign own_stb = own1 ? m1.stb   : m0.stb;
  assign own_we  = own1 ? m1.we    : m0.we;
  assign own_adr = own1 ? m1.adr   : m0.adr;
  assign own_dat = own1 ? m1.dat_w : m0.dat_w;
  assign own_sel = own1 ? m1.sel   : m0.sel;

  assign stall = own_stb & ~s.ack & ~s.err;
  assign hit   = (cnt_q == CW'(TIMEOUT));

  // last_q=0 means M0 owned last, so M1 wins a tie
  assign pick_m1 = m1.cyc &
                   (~m0.cyc | (RR_EN == 0) | ~last_q);
  assign pick_m0 = m0.cyc & ~pick_m1;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    req_cyc  = 1'b0;
    req_stb  = 1'b0;
    req_mux  = 1'b0;
    rsp_ack  = 1'b0;
    rsp_err  = 1'b0;
    rsp_dat  = '0;
    to_pulse = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        unique case (1'b1)
          pick_m1: begin
            grant_d = 2'b10;
            state_d = OWN;
          end
          pick_m0: begin
            grant_d = 2'b01;
            state_d = OWN;
          end
          default: ;
        endcase
      end

      OWN: begin
        req_mux = 1'b1;
        if (stall && hit) begin
          // watchdog expired: fail the owner, drop the slave cycle
          state_d  = ABORT;
          cnt_d    = '0;
          rsp_err  = 1'b1;
          to_pulse = 1'b1;
        end else begin
          req_cyc = own_cyc;
          req_stb = own_stb;
          rsp_ack = s.ack;
          rsp_err = s.err;
          rsp_dat = s.dat_r;
          if (stall) begin
            cnt_d = hit ? cnt_q : cnt_q + CW'(1);
          end else begin
            cnt_d = '0;
          end
          if (!own_cyc) begin
            state_d = IDLE;
            grant_d = 2'b00;
            last_d  = own1;
            cnt_d   = '0;
          end
        end
      end

      ABORT: begin
        cnt_d = '0;
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = own1;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
        cnt_d   = '0;
      end
    endcase
  end

  // a reset cycle blanks every output so no late ACK leaks out
  always_comb begin
    s.cyc    = rst_ni & req_cyc;
    s.stb    = rst_ni & req_stb;
    s.we     = rst_ni & req_mux & own_we;
    s.adr    = (rst_ni & req_mux) ? own_adr : '0;
    s.dat_w  = (rst_ni & req_mux) ? own_dat : '0;
    s.sel    = (rst_ni & req_mux) ? own_sel : '0;

    m0.ack   = rst_ni & ~own1 & rsp_ack;
    m0.err   = rst_ni & ~own1 & rsp_err;
    m0.dat_r = (rst_ni & ~own1) ? rsp_dat : '0;
    m1.ack   = rst_ni & own1 & rsp_ack;
    m1.err   = rst_ni & own1 & rsp_err;
    m1.dat_r = (rst_ni & own1) ? rsp_dat : '0;

    grant_o   = rst_ni ? grant_q : 2'b00;
    timeout_o = rst_ni & to_pulse;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: cycle table plus corner sequences.
// DUT a is round-robin, DUT b is fixed priority; both TIMEOUT=4.
module tb_wb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_dat;
  logic [3:0]  m0_sel;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_dat;
  logic [3:0]  m1_sel;
  logic        s_ack, s_err;
  logic [31:0] s_dat;

  logic [1:0] a_grant, b_grant;
  logic       a_to, b_to;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_mem_arbiter_if #(.AW(32), .DW(32)) a_m0 ();
  wb_mem_arbiter_if #(.AW(32), .DW(32)) a_m1 ();
  wb_mem_arbiter_if #(.AW(32), .DW(32)) a_s ();
  wb_mem_arbiter_if #(.AW(32), .DW(32)) b_m0 ();
  wb_mem_arbiter_if #(.AW(32), .DW(32)) b_m1 ();
  wb_mem_arbiter_if #(.AW(32), .DW(32)) b_s ();

  assign a_m0.cyc = m0_cyc;  assign b_m0.cyc = m0_cyc;
  assign a_m0.stb = m0_stb;  assign b_m0.stb = m0_stb;
  assign a_m0.we  = m0_we;   assign b_m0.we  = m0_we;
  assign a_m0.adr = m0_adr;  assign b_m0.adr = m0_adr;
  assign a_m0.dat_w = m0_dat; assign b_m0.dat_w = m0_dat;
  assign a_m0.sel = m0_sel;  assign b_m0.sel = m0_sel;
  assign a_m1.cyc = m1_cyc;  assign b_m1.cyc = m1_cyc;
  assign a_m1.stb = m1_stb;  assign b_m1.stb = m1_stb;
  assign a_m1.we  = m1_we;   assign b_m1.we  = m1_we;
  assign a_m1.adr = m1_adr;  assign b_m1.adr = m1_adr;
  assign a_m1.dat_w = m1_dat; assign b_m1.dat_w = m1_dat;
  assign a_m1.sel = m1_sel;  assign b_m1.sel = m1_sel;
  assign a_s.ack = s_ack;    assign b_s.ack = s_ack;
  assign a_s.err = s_err;    assign b_s.err = s_err;
  assign a_s.dat_r = s_dat;  assign b_s.dat_r = s_dat;

  wb_mem_arbiter #(
    .XLEN(32), .ADDR_WIDTH(32), .TIMEOUT(4), .RR_EN(1)
  ) u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .m0(a_m0), .m1(a_m1), .s(a_s),
    .grant_o(a_grant), .timeout_o(a_to)
  );

  wb_mem_arbiter #(
    .XLEN(32), .ADDR_WIDTH(32), .TIMEOUT(4), .RR_EN(0)
  ) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .m0(b_m0), .m1(b_m1), .s(b_s),
    .grant_o(b_grant), .timeout_o(b_to)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  cyc;
    logic [31:0] a0, a1;
    logic        we1;
    logic [3:0]  sel1;
    logic [31:0] d1;
    logic        ack, err;
    logic [31:0] sd;
    logic [1:0]  eg;
    logic        ecyc;
    logic [31:0] eadr;
    logic        ewe;
    logic [3:0]  esel;
    logic [31:0] ewd;
    logic [1:0]  eack, eerr;
    logic [31:0] ed0, ed1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic rst, logic [1:0] cyc,
    logic [31:0] a0, logic [31:0] a1,
    logic we1, logic [3:0] sel1, logic [31:0] d1,
    logic ack, logic err, logic [31:0] sd,
    logic [1:0] eg, logic ecyc, logic [31:0] eadr,
    logic ewe, logic [3:0] esel, logic [31:0] ewd,
    logic [1:0] eack, logic [1:0] eerr,
    logic [31:0] ed0, logic [31:0] ed1);
    vec_t v;
    v.rst = rst; v.cyc = cyc; v.a0 = a0; v.a1 = a1;
    v.we1 = we1; v.sel1 = sel1; v.d1 = d1;
    v.ack = ack; v.err = err; v.sd = sd;
    v.eg = eg; v.ecyc = ecyc; v.eadr = eadr;
    v.ewe = ewe; v.esel = esel; v.ewd = ewd;
    v.eack = eack; v.eerr = eerr; v.ed0 = ed0; v.ed1 = ed1;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0;
    m0_dat = 0; m0_sel = 4'hf;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0;
    m1_dat = 0; m1_sel = 4'hf;
    s_ack = 0; s_err = 0; s_dat = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      string p;
      v = vecs[i];
      p = $sformatf("v%0d_", i);
      @(negedge clk);
      rst_n  = v.rst;
      m0_cyc = v.cyc[0]; m0_stb = v.cyc[0];
      m1_cyc = v.cyc[1]; m1_stb = v.cyc[1];
      m0_adr = v.a0;  m1_adr = v.a1;
      m1_we  = v.we1; m1_sel = v.sel1; m1_dat = v.d1;
      s_ack  = v.ack; s_err = v.err; s_dat = v.sd;
      #2;
      chk({p, "grant"},  a_grant,    v.eg);
      chk({p, "s_cyc"},  a_s.cyc,    v.ecyc);
      chk({p, "s_stb"},  a_s.stb,    v.ecyc);
      chk({p, "s_we"},   a_s.we,     v.ewe);
      chk({p, "s_adr"},  a_s.adr,    v.eadr);
      chk({p, "s_dat"},  a_s.dat_w,  v.ewd);
      chk({p, "s_sel"},  a_s.sel,    v.esel);
      chk({p, "m0_ack"}, a_m0.ack,   v.eack[0]);
      chk({p, "m1_ack"}, a_m1.ack,   v.eack[1]);
      chk({p, "m0_err"}, a_m0.err,   v.eerr[0]);
      chk({p, "m1_err"}, a_m1.err,   v.eerr[1]);
      chk({p, "m0_dat"}, a_m0.dat_r, v.ed0);
      chk({p, "m1_dat"}, a_m1.dat_r, v.ed1);
      chk({p, "timeout"}, a_to,      1'b0);
    end
  endtask

  task automatic rr_rounds();
    logic [1:0] exp_a[4];
    exp_a[0] = 2'b10; exp_a[1] = 2'b01;
    exp_a[2] = 2'b10; exp_a[3] = 2'b01;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      s_ack = 0;
      #2;
      chk($sformatf("rr%0d_gap_a", k), a_grant, 2'b00);
      chk($sformatf("rr%0d_gap_b", k), b_grant, 2'b00);
      @(negedge clk);
      s_ack = 1;
      #2;
      chk($sformatf("rr%0d_grant_a", k), a_grant, exp_a[k]);
      chk($sformatf("rr%0d_grant_b", k), b_grant, 2'b10);
      @(negedge clk);
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      s_ack = 0;
      #2;
      chk($sformatf("rr%0d_hold_a", k), a_grant, exp_a[k]);
    end
  endtask

  task automatic watchdog_abort();
    int n;
    n = 0;
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h500;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      #2;
      if (a_to) begin
        n = i;
        break;
      end
    end
    chk("to_latency", n, 5);
    chk("to_m0_err", a_m0.err, 1'b1);
    chk("to_m0_ack", a_m0.ack, 1'b0);
    chk("to_s_stb", a_s.stb, 1'b0);
    chk("to_s_cyc", a_s.cyc, 1'b0);
    chk("to_b_pulse", b_to, 1'b1);
    @(negedge clk);
    s_ack = 1;
    #2;
    chk("to_pulse_len", a_to, 1'b0);
    chk("to_err_len", a_m0.err, 1'b0);
    chk("to_late_ack", a_m0.ack, 1'b0);
    chk("to_abort_stb", a_s.stb, 1'b0);
    chk("to_abort_grant", a_grant, 2'b01);
    @(negedge clk);
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    #2;
    chk("to_release_grant", a_grant, 2'b01);
    @(negedge clk);
    #2;
    chk("to_idle_grant", a_grant, 2'b00);
  endtask

  task automatic ack_at_limit();
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h540;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      #2;
      chk($sformatf("lim_stall%0d", i), a_to, 1'b0);
    end
    @(negedge clk);
    s_ack = 1; s_dat = 32'h0BAD_F00D;
    #2;
    chk("lim_ack", a_m0.ack, 1'b1);
    chk("lim_dat", a_m0.dat_r, 32'h0BAD_F00D);
    chk("lim_err", a_m0.err, 1'b0);
    chk("lim_to", a_to, 1'b0);
    chk("lim_stb", a_s.stb, 1'b1);
    @(negedge clk);
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    #2;
    chk("lim_hold", a_grant, 2'b01);
    @(negedge clk);
    #2;
    chk("lim_idle", a_grant, 2'b00);
  endtask

  task automatic back_to_back();
    int m0_acks, m1_acks;
    m0_acks = 0; m1_acks = 0;
    @(negedge clk);
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h600;
    #2;
    chk("b2b_idle", a_grant, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h700;
      end
      s_ack = 1; s_dat = 32'h100 + i;
      #2;
      chk($sformatf("b2b_grant%0d", i), a_grant, 2'b10);
      chk($sformatf("b2b_dat%0d", i), a_m1.dat_r, 32'h100 + i);
      m1_acks += int'(a_m1.ack);
      m0_acks += int'(a_m0.ack);
    end
    @(negedge clk);
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    #2;
    chk("b2b_release", a_grant, 2'b10);
    m0_acks += int'(a_m0.ack);
    @(negedge clk);
    #2;
    chk("b2b_gap", a_grant, 2'b00);
    @(negedge clk);
    #2;
    chk("b2b_m0_grant", a_grant, 2'b01);
    chk("b2b_s_adr", a_s.adr, 32'h700);
    chk("b2b_m1_acks", m1_acks, 3);
    chk("b2b_m0_acks", m0_acks, 0);
    @(negedge clk);
    m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // reset, then M0 read with a two-cycle slave wait
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,
      2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b01, 32'h100, 0, 0, 0, 0, 0, 0, 0,
      2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b01, 32'h100, 0, 0, 0, 0, 0, 0, 0,
      2'b01, 1, 32'h100, 0, 4'hf, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b01, 32'h100, 0, 0, 0, 0, 0, 0, 0,
      2'b01, 1, 32'h100, 0, 4'hf, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b01, 32'h100, 0, 0, 0, 0,
      1, 0, 32'hDEADBEEF,
      2'b01, 1, 32'h100, 0, 4'hf, 0, 2'b01, 2'b00,
      32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 2'b00, 32'h100, 0, 0, 0, 0, 0, 0, 0,
      2'b01, 0, 32'h100, 0, 4'hf, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,
      2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    // M1 store while M0 waits
    vecs.push_back(mk(1, 2'b11, 32'h300, 32'h2004, 1, 4'b0100,
      32'h00AB0000, 0, 0, 0,
      2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b11, 32'h300, 32'h2004, 1, 4'b0100,
      32'h00AB0000, 0, 0, 0,
      2'b10, 1, 32'h2004, 1, 4'b0100, 32'h00AB0000,
      2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b11, 32'h300, 32'h2004, 1, 4'b0100,
      32'h00AB0000, 1, 0, 32'h12345678,
      2'b10, 1, 32'h2004, 1, 4'b0100, 32'h00AB0000,
      2'b10, 2'b00, 0, 32'h12345678));
    vecs.push_back(mk(1, 2'b01, 32'h300, 32'h2004, 1, 4'b0100,
      32'h00AB0000, 0, 0, 0,
      2'b10, 0, 32'h2004, 1, 4'b0100, 32'h00AB0000,
      2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b01, 32'h300, 0, 0, 0, 0, 0, 0, 0,
      2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    // ACK and ERR together are both forwarded
    vecs.push_back(mk(1, 2'b01, 32'h300, 0, 0, 0, 0,
      1, 1, 32'hCAFEF00D,
      2'b01, 1, 32'h300, 0, 4'hf, 0, 2'b01, 2'b01,
      32'hCAFEF00D, 0));
    // reset while the slave is still acking
    vecs.push_back(mk(0, 2'b01, 32'h300, 0, 0, 0, 0,
      1, 0, 32'hCAFEF00D,
      2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b00, 32'h300, 0, 0, 0, 0,
      1, 0, 32'hCAFEF00D,
      2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    // pointer back at M0 after reset: M1 wins the tie
    vecs.push_back(mk(1, 2'b11, 32'h400, 32'h2008, 0, 4'hf, 0,
      0, 0, 0,
      2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b11, 32'h400, 32'h2008, 0, 4'hf, 0,
      1, 0, 32'h55,
      2'b10, 1, 32'h2008, 0, 4'hf, 0, 2'b10, 2'b00, 0, 32'h55));
    vecs.push_back(mk(1, 2'b00, 32'h400, 32'h2008, 0, 4'hf, 0,
      0, 0, 0,
      2'b10, 0, 32'h2008, 0, 4'hf, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,
      2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));

    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);

    run_table();
    do_reset();
    rr_rounds();
    watchdog_abort();
    ack_at_limit();
    back_to_back();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
